// File: rtl/branch_redirect_unit_if.sv
// EX-to-IF branch resolution bundle: EX result, IF prediction lookup and PC redirect handshake.
interface branch_redirect_unit_if #(
  parameter int XLEN = 64
);
  logic [XLEN-1:0] if_pc;
  logic            if_pred_taken;
  logic            ex_valid;
  logic            ex_is_branch;
  logic            ex_is_jump;
  logic [XLEN-1:0] ex_pc;
  logic            ex_pred_taken;
  logic            ex_cmp_res;
  logic [XLEN-1:0] ex_target;
  logic            ex_ready;
  logic            redir_valid;
  logic [XLEN-1:0] redir_pc;
  logic            redir_ready;
  logic            flush;

  modport master (
    output if_pc, ex_valid, ex_is_branch, ex_is_jump, ex_pc, ex_pred_taken,
           ex_cmp_res, ex_target, redir_ready,
    input  if_pred_taken, ex_ready, redir_valid, redir_pc, flush
  );

  modport slave (
    input  if_pc, ex_valid, ex_is_branch, ex_is_jump, ex_pc, ex_pred_taken,
           ex_cmp_res, ex_target, redir_ready,
    output if_pred_taken, ex_ready, redir_valid, redir_pc, flush
  );
endinterface

// File: rtl/branch_redirect_unit.sv
// Resolves EX branches/jumps, holds a PC redirect for IF and owns the 2-bit BHT; redirect/flush 1 cycle after mispredict.
// Backpressure: ex_ready drops while a redirect is pending and IF withholds redir_ready.
module branch_redirect_unit #(
  parameter int XLEN        = 64,
  parameter int BHT_ENTRIES = 64
) (
  input logic                   clk,
  input logic                   rstn,
  branch_redirect_unit_if.slave bus
);
  localparam int IDX_W = $clog2(BHT_ENTRIES);

  typedef enum logic {
    IDLE,
    PEND
  } state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] redir_pc_q, redir_pc_nxt;
  logic            flush_q, flush_nxt;
  logic [1:0]      bht [BHT_ENTRIES];

  logic             resolve;
  logic             actual;
  logic             mispredict;
  logic [XLEN-1:0]  next_pc;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             bht_upd;
  logic [1:0]       bht_cur;
  logic [1:0]       bht_nxt;
  logic             unused_pc_bits;

  assign rd_idx         = bus.if_pc[IDX_W+1:2];
  assign wr_idx         = bus.ex_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{bus.if_pc[XLEN-1:IDX_W+2], bus.if_pc[1:0]};

  assign bus.ex_ready      = (state == IDLE) | bus.redir_ready;
  assign bus.redir_valid   = (state == PEND);
  assign bus.redir_pc      = redir_pc_q;
  assign bus.flush         = flush_q;
  assign bus.if_pred_taken = bht[rd_idx][1];

  // A jump flagged as a branch too is still a jump: always taken, never trains the BHT.
  assign resolve    = bus.ex_valid & bus.ex_ready & (bus.ex_is_branch | bus.ex_is_jump);
  assign actual     = bus.ex_is_jump | bus.ex_cmp_res;
  assign next_pc    = actual ? bus.ex_target : bus.ex_pc + XLEN'(4);
  assign mispredict = resolve & (actual != bus.ex_pred_taken);
  assign bht_upd    = resolve & bus.ex_is_branch & ~bus.ex_is_jump;

  always_comb begin
    state_nxt    = state;
    redir_pc_nxt = redir_pc_q;
    flush_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (mispredict) begin
          state_nxt    = PEND;
          redir_pc_nxt = next_pc;
          flush_nxt    = 1'b1;
        end
      end
      PEND: begin
        // A mispredict here implies redir_ready: the old redirect is taken and a new one loads.
        if (mispredict) begin
          state_nxt    = PEND;
          redir_pc_nxt = next_pc;
          flush_nxt    = 1'b1;
        end else if (bus.redir_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      redir_pc_q <= '0;
      flush_q    <= 1'b0;
    end else begin
      state      <= state_nxt;
      redir_pc_q <= redir_pc_nxt;
      flush_q    <= flush_nxt;
    end
  end

  always_comb begin
    bht_cur = bht[wr_idx];
    bht_nxt = bht_cur;
    if (actual) begin
      if (bht_cur != 2'b11) bht_nxt = bht_cur + 2'b01;
    end else begin
      if (bht_cur != 2'b00) bht_nxt = bht_cur - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else if (bht_upd) begin
      bht[wr_idx] <= bht_nxt;
    end
  end
endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed vector table for the documented scenarios, then random traffic against a rule-level model.
module tb_branch_redirect_unit;
  localparam int XLEN = 64;
  localparam int NBHT = 64;

  typedef struct {
    logic            rstn;
    logic [XLEN-1:0] if_pc;
    logic            v, br, j;
    logic [XLEN-1:0] ex_pc;
    logic            pr, cmp;
    logic [XLEN-1:0] tgt;
    logic            rr;
    logic            e_pred, e_rdy, e_vld;
    logic [XLEN-1:0] e_rpc;
    logic            e_flush;
  } vec_t;

  logic clk;
  logic rstn;
  branch_redirect_unit_if #(.XLEN(XLEN)) bus ();

  branch_redirect_unit #(.XLEN(XLEN), .BHT_ENTRIES(NBHT)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state: pending redirect, its PC, flush pulse, counters 0..3 per entry.
  bit              m_vld;
  logic [XLEN-1:0] m_pc;
  bit              m_flush;
  int              m_bht [NBHT];

  function automatic int idx_of(input logic [XLEN-1:0] pc);
    return int'((pc >> 2) % NBHT);
  endfunction

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input vec_t s);
    bit rdy, resolve, actual;
    int k;
    if (!s.rstn) begin
      m_vld   = 0;
      m_pc    = '0;
      m_flush = 0;
      for (int i = 0; i < NBHT; i++) m_bht[i] = 1;
      return;
    end
    rdy     = !m_vld || s.rr;
    resolve = s.v && rdy && (s.br || s.j);
    actual  = s.j || s.cmp;
    if (resolve && (actual != s.pr)) begin
      m_vld   = 1;
      m_pc    = actual ? s.tgt : s.ex_pc + 64'd4;
      m_flush = 1;
    end else begin
      m_flush = 0;
      if (s.rr) m_vld = 0;
    end
    if (resolve && s.br && !s.j) begin
      k = idx_of(s.ex_pc);
      if (actual) m_bht[k] = (m_bht[k] + 1 > 3) ? 3 : m_bht[k] + 1;
      else        m_bht[k] = (m_bht[k] - 1 < 0) ? 0 : m_bht[k] - 1;
    end
  endtask

  task automatic apply(input vec_t s, input bit use_tbl);
    logic            e_pred, e_rdy, e_vld, e_flush;
    logic [XLEN-1:0] e_rpc;
    @(negedge clk);
    rstn              = s.rstn;
    bus.if_pc         = s.if_pc;
    bus.ex_valid      = s.v;
    bus.ex_is_branch  = s.br;
    bus.ex_is_jump    = s.j;
    bus.ex_pc         = s.ex_pc;
    bus.ex_pred_taken = s.pr;
    bus.ex_cmp_res    = s.cmp;
    bus.ex_target     = s.tgt;
    bus.redir_ready   = s.rr;
    #1;
    e_pred = use_tbl ? s.e_pred : logic'(m_bht[idx_of(s.if_pc)] >= 2);
    e_rdy  = use_tbl ? s.e_rdy  : logic'(!m_vld || s.rr);
    chk("if_pred_taken", XLEN'(bus.if_pred_taken), XLEN'(e_pred));
    chk("ex_ready", XLEN'(bus.ex_ready), XLEN'(e_rdy));
    model_step(s);
    e_vld   = use_tbl ? s.e_vld   : logic'(m_vld);
    e_rpc   = use_tbl ? s.e_rpc   : m_pc;
    e_flush = use_tbl ? s.e_flush : logic'(m_flush);
    @(posedge clk);
    #1;
    chk("redir_valid", XLEN'(bus.redir_valid), XLEN'(e_vld));
    chk("flush", XLEN'(bus.flush), XLEN'(e_flush));
    if (e_vld || !s.rstn) chk("redir_pc", bus.redir_pc, e_rpc);
  endtask

  function automatic vec_t mk(input logic rs, input logic [XLEN-1:0] ipc,
                              input logic v, input logic br, input logic j,
                              input logic [XLEN-1:0] epc, input logic pr, input logic cmp,
                              input logic [XLEN-1:0] tgt, input logic rr,
                              input logic e_pred, input logic e_rdy, input logic e_vld,
                              input logic [XLEN-1:0] e_rpc, input logic e_flush);
    vec_t r;
    r.rstn = rs; r.if_pc = ipc; r.v = v; r.br = br; r.j = j; r.ex_pc = epc;
    r.pr = pr; r.cmp = cmp; r.tgt = tgt; r.rr = rr;
    r.e_pred = e_pred; r.e_rdy = e_rdy; r.e_vld = e_vld; r.e_rpc = e_rpc; r.e_flush = e_flush;
    return r;
  endfunction

  localparam logic [XLEN-1:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

  vec_t tbl[$];
  vec_t rv;

  initial begin
    // rstn if_pc v br j ex_pc pr cmp tgt rr | pred rdy vld rpc flush
    tbl.push_back(mk(1, 'h100, 0,0,0, 'h0,   0,0, 'h0,    0,  0,1, 0,'h0,    0));
    tbl.push_back(mk(1, 'h3FC, 0,0,0, 'h0,   0,0, 'h0,    0,  0,1, 0,'h0,    0));
    tbl.push_back(mk(1, 'h100, 1,1,0, 'h100, 0,1, 'h200,  0,  0,1, 1,'h200,  1));
    tbl.push_back(mk(1, 'h100, 1,1,0, 'h180, 0,1, 'h500,  0,  1,0, 1,'h200,  0));
    tbl.push_back(mk(1, 'h180, 1,1,0, 'h180, 0,1, 'h500,  0,  0,0, 1,'h200,  0));
    tbl.push_back(mk(1, 'h180, 1,1,0, 'h180, 0,1, 'h500,  0,  0,0, 1,'h200,  0));
    tbl.push_back(mk(1, 'h180, 0,0,0, 'h0,   0,0, 'h0,    1,  0,1, 0,'h0,    0));
    tbl.push_back(mk(1, 'h104, 1,1,0, 'h104, 1,0, 'h900,  0,  0,1, 1,'h108,  1));
    tbl.push_back(mk(1, 'h104, 0,0,0, 'h0,   0,0, 'h0,    1,  0,1, 0,'h0,    0));
    tbl.push_back(mk(1, 'h10C, 1,1,0, 'h10C, 1,1, 'h900,  1,  0,1, 0,'h0,    0));
    tbl.push_back(mk(1, 'h10C, 1,1,0, 'h10C, 1,1, 'h900,  1,  1,1, 0,'h0,    0));
    tbl.push_back(mk(1, 'h10C, 1,1,0, 'h10C, 1,1, 'h900,  1,  1,1, 0,'h0,    0));
    tbl.push_back(mk(1, 'h10C, 1,1,0, 'h10C, 1,1, 'h900,  1,  1,1, 0,'h0,    0));
    tbl.push_back(mk(1, 'h10C, 1,1,0, 'h10C, 1,0, 'h900,  0,  1,1, 1,'h110,  1));
    tbl.push_back(mk(1, 'h10C, 0,0,0, 'h0,   0,0, 'h0,    1,  1,1, 0,'h0,    0));
    tbl.push_back(mk(1, 'h300, 1,0,1, 'h300, 0,0, 'h40,   0,  1,1, 1,'h40,   1));
    tbl.push_back(mk(1, 'h300, 1,1,0, 'h104, 1,0, 'h900,  1,  1,1, 1,'h108,  1));
    tbl.push_back(mk(1, 'h104, 0,0,0, 'h0,   0,0, 'h0,    0,  0,0, 1,'h108,  0));
    tbl.push_back(mk(1, 'h100, 1,1,0, 'h100, 0,0, 'h900,  1,  1,1, 0,'h0,    0));
    tbl.push_back(mk(1, 'h100, 0,0,0, 'h0,   0,0, 'h0,    1,  0,1, 0,'h0,    0));
    tbl.push_back(mk(1, 'h200, 1,1,1, 'h200, 0,0, 'h77C,  0,  0,1, 1,'h77C,  1));
    tbl.push_back(mk(1, 'h200, 0,0,0, 'h0,   0,0, 'h0,    1,  0,1, 0,'h0,    0));
    tbl.push_back(mk(1, 'h100, 0,1,0, 'h100, 1,0, 'h900,  1,  0,1, 0,'h0,    0));
    tbl.push_back(mk(1, 'h10C, 1,1,0, 'h104, 0,1, 'h1234, 0,  1,1, 1,'h1234, 1));
    tbl.push_back(mk(0, 'h10C, 1,1,0, 'h104, 0,1, 'h5550, 1,  1,1, 0,'h0,    0));
    tbl.push_back(mk(1, 'h10C, 0,0,0, 'h0,   0,0, 'h0,    0,  0,1, 0,'h0,    0));
    tbl.push_back(mk(1, 'h104, 0,0,0, 'h0,   0,0, 'h0,    0,  0,1, 0,'h0,    0));
    tbl.push_back(mk(1, TOP,   1,1,0, TOP,   1,0, 'h88,   0,  0,1, 1,'h0,    1));
    tbl.push_back(mk(1, TOP,   0,0,0, 'h0,   0,0, 'h0,    1,  0,1, 0,'h0,    0));

    rstn = 1'b0;
    bus.if_pc = '0; bus.ex_valid = 0; bus.ex_is_branch = 0; bus.ex_is_jump = 0;
    bus.ex_pc = '0; bus.ex_pred_taken = 0; bus.ex_cmp_res = 0; bus.ex_target = '0;
    bus.redir_ready = 0;
    rv = mk(0, 0, 0,0,0, 0, 0,0, 0, 0, 0,0,0, 0, 0);
    model_step(rv);
    repeat (2) @(posedge clk);

    foreach (tbl[i]) apply(tbl[i], 1'b1);

    for (int n = 0; n < 600; n++) begin
      rv.rstn  = ($urandom_range(0, 49) != 0);
      rv.if_pc = {($urandom_range(0, 3) == 0) ? {$urandom, 24'h0} : 56'h0, 8'h0} |
                 64'($urandom_range(0, 255) << 2);
      rv.v     = ($urandom_range(0, 9) < 7);
      rv.br    = $urandom_range(0, 1);
      rv.j     = ($urandom_range(0, 3) == 0);
      rv.ex_pc = ($urandom_range(0, 15) == 0) ? TOP : 64'($urandom_range(0, 255) << 2);
      rv.pr    = $urandom_range(0, 1);
      rv.cmp   = $urandom_range(0, 1);
      rv.tgt   = {$urandom, $urandom};
      rv.rr    = $urandom_range(0, 1);
      apply(rv, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
